branch_hazard_sb: RTL and testbench

//  ID-stage branch/jump hazard unit for the 5-stage MIPS pipeline; successor to the fixed 1-deep branch bubble logic.

---
 rtl/branch_hazard_sb.sv | 181 ++++++++++++++++++
 tb/tb_branch_hazard_sb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_sb.sv
// ---------------------------------------------------------------------------
// branch_hazard_sb
//   ID-stage branch/jump hazard unit with a load scoreboard.
//   A branch or jr/jalr in ID that reads a register still being produced by
//   EX, by a load sitting in MEM, or by a load that has left MEM but whose
//   data is not yet forwardable, raises branchbubble_o. That output holds
//   PC/IF-ID and inserts a bubble into ID-EX in the same cycle.
//
//   Loads leaving MEM (mem_adv_i) are tracked for LOAD_LAT-1 cycles in
//   SB_DEPTH entries. If every entry is busy and none retires this cycle,
//   the allocating load raises branchbubble_o and retries on the next cycle.
//   No load is ever dropped.
//
// Parameters
//   RA_W      register address width (r0 is never a hazard)
//   SB_DEPTH  scoreboard entries (1..8)
//   LOAD_LAT  load-to-forwardable latency (1..15); 1 disables tracking
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_rs_i, id_rt_i        ID source registers
//   id_branch_beq_i/bne_i   two-operand branches (rs, rt)
//   id_bgez/bgtz/blez/bltz  one-operand branches (rs)
//   id_jalr_i               jr/jalr (rs). id_jal_i never stalls.
//   ex_regWr_i, ex_rw_i     EX writeback enable and destination
//   mem_memtoreg_i,mem_rw_i load in MEM and its destination
//   mem_adv_i               MEM advances, so the load leaves MEM
//   branchbubble_o          combinational stall request
//   sb_full_o, sb_count_o   registered scoreboard occupancy
//
// Optional feature (macro BRANCH_HAZARD_STATS_EN)
//   Adds stall_cycles_o and sb_full_cycles_o. Both are saturating 32-bit
//   counters and are cleared by rst_i.
// ---------------------------------------------------------------------------
module branch_hazard_sb #(
    parameter int RA_W     = 5,
    parameter int SB_DEPTH = 2,
    parameter int LOAD_LAT = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [RA_W-1:0]                   id_rs_i,
    input  logic [RA_W-1:0]                   id_rt_i,
    input  logic                              id_branch_beq_i,
    input  logic                              id_branch_bne_i,
    input  logic                              id_bgez_i,
    input  logic                              id_bgtz_i,
    input  logic                              id_blez_i,
    input  logic                              id_bltz_i,
    input  logic                              id_jalr_i,
    input  logic                              id_jal_i,
    input  logic                              ex_regWr_i,
    input  logic [RA_W-1:0]                   ex_rw_i,
    input  logic                              mem_memtoreg_i,
    input  logic [RA_W-1:0]                   mem_rw_i,
    input  logic                              mem_adv_i,
    output logic                              branchbubble_o,
    output logic                              sb_full_o,
    output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count_o
`ifdef BRANCH_HAZARD_STATS_EN
   ,output logic [31:0]                       stall_cycles_o,
    output logic [31:0]                       sb_full_cycles_o
`endif
);

    localparam int       CNT_W    = $clog2(SB_DEPTH+1);
    localparam logic     TRACK    = (LOAD_LAT > 1);
    localparam logic [3:0] LAT_INIT = 4'(LOAD_LAT - 1);

    // jal writes r31 but reads nothing, so it can never stall.
    logic unused_jal;
    assign unused_jal = id_jal_i;

    logic [SB_DEPTH-1:0]           vld_q, vld_d;
    logic [SB_DEPTH-1:0][RA_W-1:0] reg_q, reg_d;
    logic [SB_DEPTH-1:0][3:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          full_q;

    logic alloc_req, alloc_done, sb_stall;
    logic two_op, one_op, need_rs, need_rt;
    logic sb_hit_rs, sb_hit_rt, hz_rs, hz_rt;

    // ---------------- scoreboard next state ----------------
    always_comb begin
        vld_d      = vld_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        alloc_done = 1'b0;
        count_d    = '0;
        alloc_req  = TRACK && mem_adv_i && mem_memtoreg_i && (mem_rw_i != '0);

        // Age every live entry. An entry at cnt==1 has finished its last
        // cycle, so its slot is free for an allocation on this same edge.
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (vld_q[i]) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
                if (cnt_q[i] == 4'd1) vld_d[i] = 1'b0;
            end
        end

        // The lowest-index free slot (after retirement) takes the load.
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (alloc_req && !vld_d[i] && !alloc_done) begin
                vld_d[i]   = 1'b1;
                reg_d[i]   = mem_rw_i;
                cnt_d[i]   = LAT_INIT;
                alloc_done = 1'b1;
            end
        end

        sb_stall = alloc_req && !alloc_done;

        for (int i = 0; i < SB_DEPTH; i++)
            count_d = count_d + CNT_W'(vld_d[i]);
    end

    // ---------------- hazard detect ----------------
    always_comb begin
        two_op  = id_branch_beq_i | id_branch_bne_i;
        one_op  = id_bgez_i | id_bgtz_i | id_blez_i | id_bltz_i;
        // jalr has priority and reads only rs, even if a branch bit is also set.
        need_rs = id_jalr_i | two_op | one_op;
        need_rt = !id_jalr_i && two_op;

        sb_hit_rs = 1'b0;
        sb_hit_rt = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            sb_hit_rs = sb_hit_rs | (vld_q[i] && (reg_q[i] == id_rs_i));
            sb_hit_rt = sb_hit_rt | (vld_q[i] && (reg_q[i] == id_rt_i));
        end

        hz_rs = (id_rs_i != '0) &&
                ((ex_regWr_i && (ex_rw_i == id_rs_i)) ||
                 (mem_memtoreg_i && (mem_rw_i == id_rs_i)) || sb_hit_rs);
        hz_rt = (id_rt_i != '0) &&
                ((ex_regWr_i && (ex_rw_i == id_rt_i)) ||
                 (mem_memtoreg_i && (mem_rw_i == id_rt_i)) || sb_hit_rt);

        // A load that cannot be allocated holds ID until a slot frees up.
        branchbubble_o = (need_rs && hz_rs) || (need_rt && hz_rt) || sb_stall;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            reg_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            full_q  <= &vld_d;
        end
    end

    assign sb_full_o  = full_q;
    assign sb_count_o = count_q;

`ifdef BRANCH_HAZARD_STATS_EN
    logic [31:0] stall_q, sfull_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            sfull_q <= '0;
        end else begin
            if (branchbubble_o && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (full_q && (sfull_q != 32'hFFFF_FFFF))         sfull_q <= sfull_q + 32'd1;
        end
    end

    assign stall_cycles_o   = stall_q;
    assign sb_full_cycles_o = sfull_q;
`endif

endmodule

// File: tb/tb_branch_hazard_sb.sv
module tb_branch_hazard_sb;

    localparam int RA_W     = 5;
    localparam int SB_DEPTH = 2;
    localparam int LOAD_LAT = 4;
    localparam int CNT_W    = $clog2(SB_DEPTH+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RA_W-1:0] id_rs = '0, id_rt = '0, ex_rw = '0, mem_rw = '0;
    logic beq = 0, bne = 0, bgez = 0, bgtz = 0, blez = 0, bltz = 0, jalr = 0, jal = 0;
    logic ex_regWr = 0, mem_memtoreg = 0, mem_adv = 0;
    logic             branchbubble, sb_full;
    logic [CNT_W-1:0] sb_count;
`ifdef BRANCH_HAZARD_STATS_EN
    logic [31:0] stall_cycles, sb_full_cycles;
    longint      m_stall = 0, m_sfull = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    branch_hazard_sb #(.RA_W(RA_W), .SB_DEPTH(SB_DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_branch_beq_i(beq), .id_branch_bne_i(bne),
        .id_bgez_i(bgez), .id_bgtz_i(bgtz), .id_blez_i(blez), .id_bltz_i(bltz),
        .id_jalr_i(jalr), .id_jal_i(jal),
        .ex_regWr_i(ex_regWr), .ex_rw_i(ex_rw),
        .mem_memtoreg_i(mem_memtoreg), .mem_rw_i(mem_rw), .mem_adv_i(mem_adv),
        .branchbubble_o(branchbubble), .sb_full_o(sb_full), .sb_count_o(sb_count)
`ifdef BRANCH_HAZARD_STATS_EN
       ,.stall_cycles_o(stall_cycles), .sb_full_cycles_o(sb_full_cycles)
`endif
    );

    // Reference model: outstanding loads kept as (register, last cycle on
    // which its data is still not forwardable). All queued loads are live now.
    int m_reg[$];
    int m_exp[$];
    int now = 0;

    function automatic bit m_hit(input int r);
        if (r == 0) return 1'b0;
        if (ex_regWr && int'(ex_rw) == r) return 1'b1;
        if (mem_memtoreg && int'(mem_rw) == r) return 1'b1;
        foreach (m_reg[k]) if (m_reg[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_alloc_req();
        return mem_adv && mem_memtoreg && (mem_rw != 0) && (LOAD_LAT > 1);
    endfunction

    function automatic bit m_full_stall();
        int busy = 0;
        foreach (m_exp[k]) if (m_exp[k] > now) busy++;
        return m_alloc_req() && (busy >= SB_DEPTH);
    endfunction

    function automatic bit m_bubble();
        bit h;
        if (jalr)                            h = m_hit(int'(id_rs));
        else if (beq || bne)                 h = m_hit(int'(id_rs)) || m_hit(int'(id_rt));
        else if (bgez || bgtz || blez || bltz) h = m_hit(int'(id_rs));
        else                                 h = 1'b0;
        return h || m_full_stall();
    endfunction

    // Advance the model and the clock by one cycle; ends at the next negedge.
    task automatic tick();
        bit bub = m_bubble();
        bit full_now = (m_reg.size() == SB_DEPTH);
        if (rst) begin
            m_reg.delete();
            m_exp.delete();
`ifdef BRANCH_HAZARD_STATS_EN
            m_stall = 0;
            m_sfull = 0;
`endif
        end else begin
            if (m_alloc_req() && !m_full_stall()) begin
                m_reg.push_back(int'(mem_rw));
                m_exp.push_back(now + LOAD_LAT - 1);
            end
`ifdef BRANCH_HAZARD_STATS_EN
            if (bub && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (full_now && m_sfull < 64'hFFFF_FFFF) m_sfull++;
`endif
        end
        now++;
        for (int k = m_exp.size() - 1; k >= 0; k--)
            if (m_exp[k] < now) begin
                m_exp.delete(k);
                m_reg.delete(k);
            end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        {beq, bne, bgez, bgtz, blez, bltz, jalr, jal} = '0;
        ex_regWr = 0; mem_memtoreg = 0; mem_adv = 0;
        id_rs = '0; id_rt = '0; ex_rw = '0; mem_rw = '0;
    endtask

    task automatic drain();
        idle();
        repeat (LOAD_LAT + 1) tick();
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick();
        rst = 0; #1;
        n_checks++; if (sb_count !== '0) $display("FAIL reset_count: got %0d want 0", sb_count); else n_pass++;
        n_checks++; if (sb_full !== 1'b0) $display("FAIL reset_full: got %b want 0", sb_full); else n_pass++;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL reset_bubble: got %b want 0", branchbubble); else n_pass++;
    endtask

    task automatic test_ex_hazard();
        drain();
        beq = 1; id_rs = 3; id_rt = 4; ex_regWr = 1; ex_rw = 4; #1;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL beq_ex_rt: got %b want 1", branchbubble); else n_pass++;
        id_rs = 0; id_rt = 0; ex_rw = 0; #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL beq_r0: got %b want 0", branchbubble); else n_pass++;
        id_rt = 4; ex_rw = 4; ex_regWr = 0; #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL beq_no_wr: got %b want 0", branchbubble); else n_pass++;
        idle(); bne = 1; id_rs = 7; mem_memtoreg = 1; mem_rw = 7; #1;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL bne_mem_load: got %b want 1", branchbubble); else n_pass++;
        idle(); bltz = 1; id_rs = 2; id_rt = 9; ex_regWr = 1; ex_rw = 9; #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL bltz_rt_ignored: got %b want 0", branchbubble); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_jal_jalr();
        idle(); jal = 1; id_rs = 9; ex_regWr = 1; ex_rw = 9; #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL jal_no_stall: got %b want 0", branchbubble); else n_pass++;
        jal = 0; jalr = 1; #1;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL jalr_rs: got %b want 1", branchbubble); else n_pass++;
        // jalr outranks beq: rt is not a source even with beq also set
        id_rs = 1; id_rt = 9; beq = 1; #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL jalr_priority: got %b want 0", branchbubble); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_load_lat();
        drain();
        mem_adv = 1; mem_memtoreg = 1; mem_rw = 5; bgtz = 1; id_rs = 5; #1;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL load_in_mem: got %b want 1", branchbubble); else n_pass++;
        tick();
        idle(); bgtz = 1; id_rs = 5;
        for (int k = 1; k < LOAD_LAT; k++) begin
            #1;
            n_checks++; if (branchbubble !== 1'b1) $display("FAIL load_track_t%0d: got %b want 1", k, branchbubble); else n_pass++;
            n_checks++; if (sb_count !== CNT_W'(1)) $display("FAIL load_count_t%0d: got %0d want 1", k, sb_count); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL load_retired: got %b want 0", branchbubble); else n_pass++;
        n_checks++; if (sb_count !== '0) $display("FAIL load_retired_count: got %0d want 0", sb_count); else n_pass++;
        idle();
    endtask

    task automatic test_full();
        drain();
        mem_adv = 1; mem_memtoreg = 1; mem_rw = 6; tick();
        mem_rw = 7; tick();
        mem_rw = 8; #1;
        n_checks++; if (sb_full !== 1'b1) $display("FAIL full_flag: got %b want 1", sb_full); else n_pass++;
        n_checks++; if (sb_count !== CNT_W'(2)) $display("FAIL full_count: got %0d want 2", sb_count); else n_pass++;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL full_stall: got %b want 1", branchbubble); else n_pass++;
        tick();
        #1;   // r6 retires this cycle, so r8 fits
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL full_retire_alloc: got %b want 0", branchbubble); else n_pass++;
        tick();
        idle(); bltz = 1; id_rs = 8; #1;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL full_r8_tracked: got %b want 1", branchbubble); else n_pass++;
        n_checks++; if (sb_count !== CNT_W'(2)) $display("FAIL full_r8_count: got %0d want 2", sb_count); else n_pass++;
        tick(); tick(); tick(); #1;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL full_r8_retired: got %b want 0", branchbubble); else n_pass++;
        idle();
    endtask

    task automatic test_rst_mid();
        drain();
        mem_adv = 1; mem_memtoreg = 1; mem_rw = 10; tick();
        mem_rw = 11; tick();
        idle(); bgez = 1; id_rs = 10; #1;
        n_checks++; if (sb_count !== CNT_W'(2)) $display("FAIL rst_mid_pre_count: got %0d want 2", sb_count); else n_pass++;
        rst = 1; #1;
        n_checks++; if (branchbubble !== 1'b1) $display("FAIL rst_mid_pre_bubble: got %b want 1", branchbubble); else n_pass++;
        tick();
        rst = 0; #1;
        n_checks++; if (sb_count !== '0) $display("FAIL rst_mid_count: got %0d want 0", sb_count); else n_pass++;
        n_checks++; if (branchbubble !== 1'b0) $display("FAIL rst_mid_bubble: got %b want 0", branchbubble); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int kind = $urandom_range(0, 8);
            idle();
            case (kind)
                1: beq = 1;  2: bne = 1;  3: bgez = 1; 4: bgtz = 1;
                5: blez = 1; 6: bltz = 1; 7: jalr = 1; 8: jal = 1;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) beq = 1;
            id_rs        = RA_W'($urandom_range(0, 7));
            id_rt        = RA_W'($urandom_range(0, 7));
            ex_rw        = RA_W'($urandom_range(0, 7));
            mem_rw       = RA_W'($urandom_range(0, 7));
            ex_regWr     = ($urandom_range(0, 1) == 1);
            mem_memtoreg = ($urandom_range(0, 9) < 7);
            mem_adv      = ($urandom_range(0, 9) < 7);
            rst          = ($urandom_range(0, 49) == 0);
            #1;
            n_checks++;
            if (branchbubble !== m_bubble())
                $display("FAIL rand_bubble c%0d: got %b want %b", c, branchbubble, m_bubble());
            else n_pass++;
            n_checks++;
            if (sb_count !== CNT_W'(m_reg.size()) || sb_full !== (m_reg.size() == SB_DEPTH))
                $display("FAIL rand_occupancy c%0d: got cnt=%0d full=%b want cnt=%0d full=%b",
                         c, sb_count, sb_full, m_reg.size(), (m_reg.size() == SB_DEPTH));
            else n_pass++;
`ifdef BRANCH_HAZARD_STATS_EN
            n_checks++;
            if (stall_cycles !== 32'(m_stall) || sb_full_cycles !== 32'(m_sfull))
                $display("FAIL rand_stats c%0d: got %0d/%0d want %0d/%0d",
                         c, stall_cycles, sb_full_cycles, m_stall, m_sfull);
            else n_pass++;
`endif
            tick();
        end
        rst = 0; idle();
    endtask

`ifdef BRANCH_HAZARD_STATS_EN
    task automatic test_stats();
        rst = 1; idle(); tick(); rst = 0;
        beq = 1; id_rs = 3; ex_regWr = 1; ex_rw = 3;
        repeat (5) tick();
        idle(); #1;
        n_checks++; if (stall_cycles !== 32'd5) $display("FAIL stats_stall5: got %0d want 5", stall_cycles); else n_pass++;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_ex_hazard();
        test_jal_jalr();
        test_load_lat();
        test_full();
        test_rst_mid();
        test_random();
`ifdef BRANCH_HAZARD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
